// File: rtl/rc5_key_schedule.sv
// RC5 key expansion: byte-serial key load into L, S table init, 3*max(T,C) mixing passes, registered S read port.
// Build option: define RC6_SCHEDULE_EN to size S for the RC6 schedule (T = 2R+4) instead of RC5 (T = 2(R+1)).
module rc5_key_schedule #(
    parameter int          W = 32,
    parameter int          R = 12,
    parameter int          B = 16,
    parameter logic [63:0] P = 64'h0000_0000_B7E1_5163,
    parameter logic [63:0] Q = 64'h0000_0000_9E37_79B9,
`ifdef RC6_SCHEDULE_EN
    localparam int         T = 2 * R + 4,
`else
    localparam int         T = 2 * (R + 1),
`endif
    localparam int         AW = $clog2(T)
) (
    input  logic          clk1,
    input  logic          rst,
    // Key bytes move on a rising clk1 edge where key_valid && key_ready; key_valid is a don't-care while key_ready is low.
    input  logic          key_valid,
    input  logic [7:0]    key_byte,
    output logic          key_ready,
    input  logic          start,
    output logic          busy,
    output logic          done,
    input  logic [AW-1:0] s_addr,
    output logic [W-1:0]  s_data,
    output logic [1:0]    fsm_state
);
    localparam int U  = W / 8;
    localparam int UB = $clog2(U);
    localparam int C  = ((B + U - 1) / U > 1) ? (B + U - 1) / U : 1;
    localparam int CW = (C > 1) ? $clog2(C) : 1;
    localparam int N  = 3 * ((T > C) ? T : C);
    localparam int NW = $clog2(N + 1);
    localparam int LW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        MIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [8:0]      byte_cnt;
    logic [NW-1:0]   cnt;
    logic [W-1:0]    s_mem [T];
    logic [W-1:0]    l_mem [C];
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    s_prev;
    logic [AW-1:0]   mi;
    logic [CW-1:0]   mj;
    logic            byte_acc;
    logic            start_acc;
    logic [CW-1:0]   l_wr_idx;
    logic [UB-1:0]   l_wr_off;
    logic [W-1:0]    a_new;
    logic [W-1:0]    ab_sum;
    logic [W-1:0]    b_new;
    logic [W-1:0]    init_val;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] sh);
        logic [2*W-1:0] dbl;
        dbl = {x, x} << sh;
        return dbl[2*W-1:W];
    endfunction

    assign key_ready = (state == IDLE) && (byte_cnt < 9'(B));
    assign byte_acc  = key_valid && key_ready;
    assign start_acc = start && (state == IDLE) && (byte_cnt == 9'(B));
    assign l_wr_idx  = CW'(byte_cnt >> UB);
    assign l_wr_off  = byte_cnt[UB-1:0];
    assign fsm_state = state;

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start_acc) state_nx = INIT;
            INIT: begin
                busy = 1'b1;
                if (cnt == NW'(T - 1)) state_nx = MIX;
            end
            MIX: begin
                busy = 1'b1;
                if (cnt == NW'(N - 1)) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst)                                 cnt <= '0;
        else if (state_nx != state)               cnt <= '0;
        else if (state == INIT || state == MIX)   cnt <= cnt + NW'(1);
    end

    // One mixing step: the new A feeds straight into the L update of the same cycle.
    always_comb begin
        a_new    = rotl(s_mem[mi] + a_reg + b_reg, LW'(3));
        ab_sum   = a_new + b_reg;
        b_new    = rotl(l_mem[mj] + ab_sum, ab_sum[LW-1:0]);
        init_val = (cnt == '0) ? P[W-1:0] : s_prev + Q[W-1:0];
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            s_prev   <= '0;
            mi       <= '0;
            mj       <= '0;
            for (int k = 0; k < T; k++) s_mem[k] <= '0;
            for (int k = 0; k < C; k++) l_mem[k] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (byte_acc) begin
                        l_mem[l_wr_idx][{l_wr_off, 3'b000} +: 8] <= key_byte;
                        byte_cnt <= byte_cnt + 9'd1;
                    end
                end
                INIT: begin
                    s_mem[cnt[AW-1:0]] <= init_val;
                    s_prev <= init_val;
                    a_reg  <= '0;
                    b_reg  <= '0;
                    mi     <= '0;
                    mj     <= '0;
                end
                MIX: begin
                    s_mem[mi] <= a_new;
                    l_mem[mj] <= b_new;
                    a_reg     <= a_new;
                    b_reg     <= b_new;
                    mi        <= (mi == AW'(T - 1)) ? '0 : mi + AW'(1);
                    mj        <= (mj == CW'(C - 1)) ? '0 : mj + CW'(1);
                end
                DONE: begin
                    // Key material is wiped once the schedule is complete; S is kept for readout.
                    byte_cnt <= '0;
                    for (int k = 0; k < C; k++) l_mem[k] <= '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst)                   s_data <= '0;
        else if (32'(s_addr) < T)   s_data <= s_mem[s_addr];
        else                        s_data <= '0;
    end

endmodule
